// File: rtl/bch_gf_pkg.sv
// Shared GF(2^10) constants and the exponentiation FSM state type for the BCH decoder.
package bch_gf_pkg;
    localparam int              GF_M       = 10;
    localparam logic [GF_M-1:0] GF_POLY    = 10'h009;  // x^10 = x^3 + 1
    localparam logic [GF_M-1:0] GF_ONE     = 10'h001;
    localparam logic [GF_M-1:0] GF_INV_EXP = 10'd1022;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } pow_state_e;
endpackage

// File: rtl/gfmult.sv
// Combinational GF(2^10) multiplier, polynomial basis, MSB-first shift-and-add with reduction.
module gfmult
    import bch_gf_pkg::*;
(
    input  logic [GF_M-1:0] a,
    input  logic [GF_M-1:0] b,
    output logic [GF_M-1:0] p
);
    logic [GF_M-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = GF_M - 1; i >= 0; i--) begin
            acc = {acc[GF_M-2:0], 1'b0} ^ (acc[GF_M-1] ? GF_POLY : '0);
            if (b[i]) acc = acc ^ a;
        end
        p = acc;
    end
endmodule

// File: rtl/bch_gf_pow_seq.sv
// Sequential GF(2^10) a^e by MSB-first square-and-multiply on one shared multiplier;
// e = 1022 gives the field inverse used by the error-locator step.
module bch_gf_pow_seq
    import bch_gf_pkg::*;
#(
    parameter int M     = GF_M,
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_a,
    input  logic [EXP_W-1:0] in_e,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_c,
    output logic             out_zero
);
    localparam int          IDX_W    = 4;
    localparam [IDX_W-1:0]  IDX_LAST = IDX_W'(EXP_W - 1);

    pow_state_e       state_q, state_d;
    logic [M-1:0]     a_q, a_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic [M-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [M-1:0]     mul_b, prod;

    // SQ squares the accumulator, MUL folds in the base.
    assign mul_b = (state_q == MUL) ? a_q : acc_q;

    gfmult u_gfmult (
        .a (acc_q),
        .b (mul_b),
        .p (prod)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        e_d       = e_q;
        acc_d     = acc_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d       = in_a;
                    e_d       = in_e;
                    acc_d     = GF_ONE;
                    bit_idx_d = IDX_LAST;
                    state_d   = SQ;
                end
            end
            SQ: begin
                acc_d = prod;
                if (e_q[bit_idx_q])        state_d = MUL;
                else if (bit_idx_q == '0)  state_d = DONE;
                else                       bit_idx_d = bit_idx_q - 1'b1;
            end
            MUL: begin
                acc_d = prod;
                if (bit_idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                    state_d   = SQ;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            e_q       <= '0;
            acc_q     <= GF_ONE;
            bit_idx_q <= IDX_LAST;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            e_q       <= e_d;
            acc_q     <= acc_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // All outputs decode registered state only; data is gated to zero outside DONE.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_c     = out_valid ? acc_q : '0;
    assign out_zero  = out_valid && (a_q == '0) && (e_q != '0);
endmodule

// File: tb/tb_bch_gf_pow_seq.sv
// Scoreboard bench for bch_gf_pow_seq: directed vectors, reset abort, backpressure, full inversion sweep.
module tb_bch_gf_pow_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_a = '0;
    logic [9:0] in_e = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] out_c;
    logic       out_zero;

    bch_gf_pow_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_e      (in_e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] c;
        logic       z;
        int         lat;
        int         acc_cyc;
        logic [9:0] a;
        bit         inv;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   rand_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Independent reference: carry-less product then reduction by x^10+x^3+1.
    function automatic logic [9:0] gmul(input logic [9:0] a, input logic [9:0] b);
        logic [18:0] t;
        t = '0;
        for (int i = 0; i < 10; i++) if (b[i]) t = t ^ (19'(a) << i);
        for (int i = 18; i >= 10; i--) if (t[i]) t = t ^ (19'h409 << (i - 10));
        return t[9:0];
    endfunction

    function automatic logic [9:0] gpow(input logic [9:0] a, input logic [9:0] e);
        logic [9:0] r, base;
        r = 10'h001;
        base = a;
        for (int i = 0; i < 10; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        return r;
    endfunction

    // Monitor: compares whenever a result is presented and accepted.
    logic       prev_v = 1'b0, prev_hs = 1'b0, prev_z = 1'b0;
    logic [9:0] prev_c = '0;
    always @(negedge clk) begin
        exp_t ent;
        if (!rst_n) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_v && !prev_hs)
                chk(out_valid && out_c == prev_c && out_zero == prev_z, "hold_stable",
                    {out_valid, out_zero, out_c}, {1'b1, prev_z, prev_c});
            if (!out_valid) begin
                if (prev_v) chk(out_c == 10'h0 && !out_zero, "idle_outputs_zero",
                                {out_zero, out_c}, 0);
            end else if (sb.size() == 0) begin
                chk(1'b0, "unexpected_out", out_c, 0);
            end else begin
                if (!prev_v)
                    chk(cyc - sb[0].acc_cyc == sb[0].lat, "latency",
                        cyc - sb[0].acc_cyc, sb[0].lat);
                if (out_ready) begin
                    ent = sb.pop_front();
                    chk(out_c == ent.c, "out_c", out_c, ent.c);
                    chk(out_zero == ent.z, "out_zero", out_zero, ent.z);
                    if (ent.inv) chk(gmul(ent.a, out_c) == 10'h001, "a_times_inv", gmul(ent.a, out_c), 1);
                end
            end
            prev_v  = out_valid;
            prev_hs = out_valid && out_ready;
            prev_c  = out_c;
            prev_z  = out_zero;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk(1'b0, "ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [9:0] a, input logic [9:0] e, input logic [9:0] c,
                         input logic z, input bit inv, input bit push);
        exp_t ent;
        wait_ready();
        in_valid = 1'b1;
        in_a     = a;
        in_e     = e;
        ent.c = c; ent.z = z; ent.a = a; ent.inv = inv;
        ent.lat = 10 + $countones(e);
        ent.acc_cyc = cyc + 1;
        if (push) sb.push_back(ent);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(sb.size() == 0, "drain_timeout", sb.size(), 0);
    endtask

    initial begin
        // Reset / idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk(out_c == 10'h0 && !out_zero, "rst_out_c", {out_zero, out_c}, 0);
        #1 rst_n = 1'b1;

        // Reset mid-operation aborts without a result
        issue(10'h002, 10'd1022, 10'h0, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(in_ready == 1'b1 && out_valid == 1'b0, "midop_reset", {in_ready, out_valid}, 2'b10);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk(in_ready == 1'b1, "midop_idle_after", in_ready, 1);

        // Directed vectors
        issue(10'h002, 10'd1022, 10'h204, 1'b0, 1'b0, 1'b1);
        issue(10'h002, 10'd10,   10'h009, 1'b0, 1'b0, 1'b1);
        issue(10'h002, 10'd2,    10'h004, 1'b0, 1'b0, 1'b1);
        issue(10'h000, 10'd1022, 10'h000, 1'b1, 1'b0, 1'b1);
        issue(10'h000, 10'd0,    10'h001, 1'b0, 1'b0, 1'b1);
        issue(10'h3A5, 10'd0,    10'h001, 1'b0, 1'b0, 1'b1);
        issue(10'h001, 10'd1022, 10'h001, 1'b0, 1'b0, 1'b1);
        issue(10'h3A5, 10'd1023, 10'h001, 1'b0, 1'b0, 1'b1);
        issue(10'h002, 10'd1023, 10'h001, 1'b0, 1'b0, 1'b1);
        issue(10'h000, 10'd1,    10'h000, 1'b1, 1'b0, 1'b1);
        drain();

        // Backpressure: result held 7 cycles while input pulses are ignored
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(10'h002, 10'd2, 10'h004, 1'b0, 1'b0, 1'b1);
        begin
            int n = 0;
            @(negedge clk);
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk(out_valid == 1'b1, "bp_wait_valid", out_valid, 1);
        end
        for (int k = 0; k < 7; k++) begin
            chk(in_ready == 1'b0, "bp_in_ready_low", in_ready, 0);
            in_valid = 1'b1;
            in_a     = 10'h155;
            in_e     = 10'd5;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
        end
        chk(out_valid == 1'b1 && out_c == 10'h004, "bp_still_held", {out_valid, out_c}, {1'b1, 10'h004});
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(in_ready == 1'b1 && out_valid == 1'b0, "bp_release", {in_ready, out_valid}, 2'b10);
        repeat (25) @(negedge clk);
        chk(in_ready == 1'b1, "bp_no_ghost_op", in_ready, 1);
        drain();

        // Full inversion sweep with random consumer stalls
        rand_stall = 1'b1;
        for (int a = 1; a < 1024; a++)
            issue(10'(a), 10'd1022, gpow(10'(a), 10'd1022), 1'b0, 1'b1, 1'b1);
        drain();
        rand_stall = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
